// File: rtl/serial_pow2_divider_if.sv
// Request/response handshake bundle for serial_pow2_divider.
// The master drives requests and consumes results; the slave is the divider.
interface serial_pow2_divider_if #(
    parameter int N  = 8,
    parameter int SW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_a;
    logic [SW-1:0] in_shamt;
    logic          in_trunc;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_res;

    modport master (
        output in_valid,
        output in_a,
        output in_shamt,
        output in_trunc,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_res
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_shamt,
        input  in_trunc,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_res
    );
endinterface

// File: rtl/serial_pow2_divider.sv
// Signed divide by 2^s, one arithmetic shift per cycle.
// Floor mode is a plain shift; truncate mode adds back one when bits were lost.
module serial_pow2_divider #(
    parameter int N  = 8,
    parameter int SW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_pow2_divider_if.slave bus,
    output logic                 busy
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sticky_q, sticky_d;
    logic          mode_q, mode_d;
    logic [N-1:0]  res_q, res_d;

    logic          accept;
    logic          load;
    logic [CW-1:0] clamp;

    assign bus.in_ready  = (state_q == IDLE)
                         | ((state_q == DONE) & bus.out_ready);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_res   = res_q;
    assign busy          = (state_q != IDLE);
    assign accept        = bus.in_valid & bus.in_ready;

    // Shifting N times already leaves only sign bits, so stop there.
    always_comb begin
        if (32'(bus.in_shamt) >= 32'(N)) begin
            clamp = CW'(N);
        end else begin
            clamp = CW'(bus.in_shamt);
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        mode_d   = mode_q;
        res_d    = res_q;
        load     = 1'b0;
        unique case (state_q)
            IDLE: begin
                load = accept;
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    acc_d    = {acc_q[N-1], acc_q[N-1:1]};
                    sticky_d = sticky_q | acc_q[0];
                    cnt_d    = cnt_q - 1'b1;
                end else begin
                    // Negative with lost bits: step from floor toward zero.
                    res_d   = acc_q
                            + N'(mode_q & acc_q[N-1] & sticky_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    load    = accept;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (load) begin
            acc_d    = bus.in_a;
            mode_d   = bus.in_trunc;
            cnt_d    = clamp;
            sticky_d = 1'b0;
            state_d  = SHIFT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            mode_q   <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            mode_q   <= mode_d;
            res_q    <= res_d;
        end
    end
endmodule

// File: tb/tb_serial_pow2_divider.sv
// Directed bench for serial_pow2_divider (N=8, SW=4).
// Hand-computed vectors plus an in-order back-to-back stream.
module tb_serial_pow2_divider;
    logic clk;
    logic rst_n;
    logic busy;

    int n_assert;
    int n_fail;

    serial_pow2_divider_if #(.N(8), .SW(4)) bus ();

    serial_pow2_divider #(.N(8), .SW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] a,
                                         input logic [3:0] s,
                                         input logic t);
        int av;
        int sc;
        int d;
        int q;
        av = int'($signed(a));
        sc = (s > 4'd8) ? 8 : int'(s);
        d  = 1 << sc;
        q  = av / d;
        if (!t && av < 0 && (av % d) != 0) q = q - 1;
        return q[7:0];
    endfunction

    task automatic run_op(input string tag,
                          input logic [7:0] a,
                          input logic [3:0] s,
                          input logic t,
                          input logic [7:0] exp,
                          input int lat);
        int cyc;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_shamt = s;
        bus.in_trunc = t;
        check({tag, "/rdy"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_a     = 8'h00;
        bus.in_shamt = 4'h0;
        bus.in_trunc = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "/lat"}, 32'(cyc), 32'(lat));
        check({tag, "/res"}, 32'(bus.out_res), 32'(exp));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "/idle"},
              32'({bus.out_valid, busy, bus.in_ready}),
              32'(3'b001));
    endtask

    logic [7:0] ra   [16];
    logic [3:0] rs   [16];
    logic       rt   [16];
    logic [7:0] rexp [16];
    logic [7:0] rgot [16];

    initial begin
        int stale;
        int cyc;
        int idx;
        int got;
        int viol;
        logic hs;
        logic acc;

        n_assert      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 8'h00;
        bus.in_shamt  = 4'h0;
        bus.in_trunc  = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_state",
              32'({bus.out_valid, busy, bus.in_ready, bus.out_res}),
              32'({1'b0, 1'b0, 1'b1, 8'h00}));
        rst_n = 1'b1;

        // Reset in the middle of an operation.
        bus.in_valid = 1'b1;
        bus.in_a     = 8'hEB;
        bus.in_shamt = 4'd5;
        bus.in_trunc = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("mid_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset",
              32'({bus.out_valid, busy, bus.in_ready, bus.out_res}),
              32'({1'b0, 1'b0, 1'b1, 8'h00}));
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid || busy || bus.out_res != 8'h00)
                stale++;
        end
        bus.out_ready = 1'b0;
        check("no_stale", 32'(stale), 32'd0);

        run_op("eb_s2_floor", 8'hEB, 4'd2,  1'b0, 8'hFA, 3);
        run_op("eb_s2_trunc", 8'hEB, 4'd2,  1'b1, 8'hFB, 3);
        run_op("2d_s3_floor", 8'h2D, 4'd3,  1'b0, 8'h05, 4);
        run_op("2d_s3_trunc", 8'h2D, 4'd3,  1'b1, 8'h05, 4);
        run_op("f0_s4_floor", 8'hF0, 4'd4,  1'b0, 8'hFF, 5);
        run_op("f0_s4_trunc", 8'hF0, 4'd4,  1'b1, 8'hFF, 5);
        run_op("5a_s0_trunc", 8'h5A, 4'd0,  1'b1, 8'h5A, 1);
        run_op("93_s0_floor", 8'h93, 4'd0,  1'b0, 8'h93, 1);
        run_op("80_s7_trunc", 8'h80, 4'd7,  1'b1, 8'hFF, 8);
        run_op("80_s9_floor", 8'h80, 4'd9,  1'b0, 8'hFF, 9);
        run_op("80_s9_trunc", 8'h80, 4'd9,  1'b1, 8'h00, 9);
        run_op("7f_sf_floor", 8'h7F, 4'd15, 1'b0, 8'h00, 9);
        run_op("7f_sf_trunc", 8'h7F, 4'd15, 1'b1, 8'h00, 9);

        // Backpressure: result held while a new request waits.
        bus.in_valid = 1'b1;
        bus.in_a     = 8'h2D;
        bus.in_shamt = 4'd3;
        bus.in_trunc = 1'b0;
        @(posedge clk); #1;
        bus.in_a     = 8'h10;
        bus.in_shamt = 4'd1;
        bus.in_trunc = 1'b1;
        cyc = 0;
        while (!bus.out_valid && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp_lat", 32'(cyc), 32'd4);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold",
                  32'({bus.out_valid, bus.in_ready, busy, bus.out_res}),
                  32'({1'b1, 1'b0, 1'b1, 8'h05}));
            @(posedge clk); #1;
        end
        check("bp_hold_end", 32'(bus.out_res), 32'h05);
        bus.out_ready = 1'b1;
        #1;
        check("bp_rdy", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("bp_accept",
              32'({bus.out_valid, busy}), 32'({1'b0, 1'b1}));
        cyc = 0;
        while (!bus.out_valid && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp2_lat", 32'(cyc), 32'd2);
        check("bp2_res", 32'(bus.out_res), 32'h08);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // Back-to-back stream.
        for (int i = 0; i < 16; i++) begin
            ra[i]   = 8'($urandom);
            rs[i]   = 4'($urandom_range(0, 15));
            rt[i]   = 1'($urandom);
            rexp[i] = model(ra[i], rs[i], rt[i]);
            rgot[i] = 8'h00;
        end
        idx  = 0;
        got  = 0;
        viol = 0;
        cyc  = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = ra[0];
        bus.in_shamt  = rs[0];
        bus.in_trunc  = rt[0];
        while (got < 16 && cyc < 400) begin
            hs  = bus.out_valid;
            acc = bus.in_valid & bus.in_ready;
            if (hs) begin
                rgot[got] = bus.out_res;
                got++;
                if (idx < 16 && !acc) viol++;
            end
            if (acc && idx > 0 && !hs) viol++;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 16) begin
                    bus.in_a     = ra[idx];
                    bus.in_shamt = rs[idx];
                    bus.in_trunc = rt[idx];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_count", 32'(got), 32'd16);
        check("b2b_accepts", 32'(idx), 32'd16);
        check("b2b_overlap", 32'(viol), 32'd0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("b2b_res%0d", i),
                  32'(rgot[i]), 32'(rexp[i]));
        end
        @(posedge clk); #1;
        check("b2b_idle",
              32'({bus.out_valid, busy}), 32'({1'b0, 1'b0}));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
